// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions: serial FSM states and width limits.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bundle between an ALU sequencer and the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );

endinterface

// File: rtl/serial_subtractor_fs.sv
// 1-bit full-subtractor cell, shared with the ALU datapath.
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = x_i ^ y_i ^ bin_i;
    assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single borrow flop.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_subtractor: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_fs (
        .x_i   (sa_q[0]),
        .y_i   (sb_q[0]),
        .bin_i (borrow_q),
        .d_o   (cell_d),
        .bo_o  (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    sa_d     = bus.a;
                    sb_d     = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                sr_d     = {cell_d, sr_q[WIDTH-1:1]};
                borrow_d = cell_bo;
                cnt_d    = cnt_q + 1'b1;
                // Overflow: borrow into the MSB differs from borrow out of it
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {cell_d, sr_q[WIDTH-1:1]};
                    bout_d  = cell_bo;
                    ovf_d   = cell_bo ^ borrow_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8 and 13.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(13)) if13 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_subtractor #(.WIDTH(13)) u_dut13 (
        .clk (clk),
        .rst (rst),
        .bus (if13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb,
                       input logic eo, input string tag);
        int lat;
        int nbusy;
        int both;
        lat = -1;
        nbusy = 0;
        both = 0;
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (if8.busy && if8.done) both = 1;
            if (if8.busy) nbusy++;
            if (if8.done) begin
                lat = k - 1;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'd8);
        chk({tag, ".busy"}, 32'(nbusy), 32'd8);
        chk({tag, ".excl"}, 32'(both), 32'd0);
        chk({tag, ".diff"}, 32'(if8.diff), 32'(ed));
        chk({tag, ".bout"}, 32'(if8.bout), 32'(eb));
        chk({tag, ".ovf"}, 32'(if8.ovf), 32'(eo));
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(if8.done), 32'd0);
    endtask

    task automatic op13(input logic [12:0] a, input logic [12:0] b,
                        input logic [12:0] ed, input logic eb,
                        input logic eo, input string tag);
        int lat;
        lat = -1;
        @(negedge clk);
        if13.start = 1'b1;
        if13.a = a;
        if13.b = b;
        @(posedge clk);
        #1;
        if13.start = 1'b0;
        if13.a = 13'($urandom);
        if13.b = 13'($urandom);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (if13.done) begin
                lat = k - 1;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'd13);
        chk({tag, ".diff"}, 32'(if13.diff), 32'(ed));
        chk({tag, ".bout"}, 32'(if13.bout), 32'(eb));
        chk({tag, ".ovf"}, 32'(if13.ovf), 32'(eo));
    endtask

    initial begin
        logic [7:0]  ra8, rb8, rd8;
        logic [12:0] ra13, rb13, rd13;
        int          ndone;
        int          t1, t2;
        logic [7:0]  dval;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        if8.start = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if13.start = 1'b0;
        if13.a = '0;
        if13.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.busy", 32'(if8.busy), 32'd0);
        chk("rst.done", 32'(if8.done), 32'd0);
        chk("rst.diff", 32'(if8.diff), 32'd0);
        chk("rst.bout", 32'(if8.bout), 32'd0);
        chk("rst.ovf", 32'(if8.ovf), 32'd0);
        chk("rst.diff13", 32'(if13.diff), 32'd0);

        op8(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0, "v5a_21");
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "v00_01");
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "v80_01");
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "v7f_ff");

        // reset mid-run: results from v7f_ff must clear, no done
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'h5A;
        if8.b = 8'h21;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(if8.busy), 32'd0);
        chk("abort.done", 32'(if8.done), 32'd0);
        chk("abort.diff", 32'(if8.diff), 32'd0);
        chk("abort.bout", 32'(if8.bout), 32'd0);
        chk("abort.ovf", 32'(if8.ovf), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) ndone++;
        end
        chk("abort.nodone", 32'(ndone), 32'd0);
        op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "v03_05");

        // rst wins over start
        @(negedge clk);
        rst = 1'b1;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if8.start = 1'b0;
        @(negedge clk);
        chk("rststart.busy", 32'(if8.busy), 32'd0);

        // second start during RUN is ignored
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'h5A;
        if8.b = 8'h21;
        @(posedge clk);
        #1 if8.start = 1'b0;
        ndone = 0;
        dval = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 3) begin
                if8.start = 1'b1;
                if8.a = 8'h10;
                if8.b = 8'h01;
            end
            if (k == 4) if8.start = 1'b0;
            if (if8.done) begin
                ndone++;
                dval = if8.diff;
            end
        end
        chk("ign.ndone", 32'(ndone), 32'd1);
        chk("ign.diff", 32'(dval), 32'h39);

        // start held high: back-to-back issue
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'h80;
        if8.b = 8'h01;
        t1 = -1;
        t2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if8.done) begin
                if (t1 < 0) t1 = k;
                else begin
                    t2 = k;
                    if8.start = 1'b0;
                    break;
                end
            end
        end
        if8.start = 1'b0;
        chk("b2b.space", 32'(t2 - t1), 32'd10);
        chk("b2b.diff", 32'(if8.diff), 32'h7F);
        repeat (3) @(negedge clk);
        chk("b2b.idle", 32'(if8.busy), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            rd8 = ra8 - rb8;
            op8(ra8, rb8, rd8, ra8 < rb8,
                (ra8[7] ^ rb8[7]) & (rd8[7] ^ ra8[7]), "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            ra13 = 13'($urandom);
            rb13 = 13'($urandom);
            rd13 = ra13 - rb13;
            op13(ra13, rb13, rd13, ra13 < rb13,
                 (ra13[12] ^ rb13[12]) & (rd13[12] ^ ra13[12]), "rnd13");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing diff = a − b, one bit per clock, LSB first. It uses a single borrow flip-flop and a 1-bit full-subtractor cell, which makes it the inverse-operation counterpart of the team's 1-bit full-adder ALU cell. A start/done handshake lets a sequencer or ALU controller issue one subtraction at a time. It serves the ALU datapath where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  minuend (unsigned or two's complement), sampled on the accepting edge
- b  input  WIDTH  subtrahend, sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a − b mod 2^WIDTH, registered
- bout  output  1  final borrow; 1 iff a < b (unsigned)
- ovf  output  1  signed overflow of a − b

## Operation
- FSM states:
  - IDLE: start=1 → RUN. On this edge, load shift regs sa←a and sb←b, borrow←0, cnt←0.
  - RUN: every edge:
    - Cell computes d = sa[0]^sb[0]^borrow, bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
    - sa and sb shift right; d shifts into MSB of result shift reg sr.
    - borrow←bo; cnt←cnt+1.
    - On cnt=WIDTH−1 the FSM moves to DONE. On the same edge:
      - diff←{d, sr[WIDTH−1:1]}
      - bout←bo
      - ovf←bo^borrow (borrow into MSB xor borrow out)
  - DONE: done=1 for exactly one cycle → IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. The requester must hold or reassert start in IDLE.
- a and b may change freely after the accepting edge.
- diff, bout and ovf hold their last values until the next final RUN edge. They do not glitch during RUN.
- cnt width is $clog2(WIDTH). cnt wraps only via reload in IDLE.
- Reset values: state IDLE, busy 0, done 0, diff 0, bout 0, ovf 0, borrow 0, cnt 0, sa/sb/sr 0.
- rst during RUN or DONE aborts the operation. There is no done pulse, and outputs return to reset values on that edge.
- rst and start asserted together: rst wins; the FSM stays in IDLE.

## Timing
- Edge E0 samples start in IDLE. busy is high from after E0 through E(WIDTH).
- done is high in the cycle after edge E(WIDTH), giving a latency of WIDTH cycles (8 for the default).
- Minimum issue interval is WIDTH+2 cycles: RUN WIDTH, DONE 1, IDLE 1.
- busy and done are never high simultaneously. done never lasts more than one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE) as a 2-bit typedef
  - the WIDTH range limits used by assertions
- One sub-module, full_subtractor (x, y, bin → d, bo), is purely combinational and instantiated once. Keep it as a separate module so the ALU can reuse it.
- The top level contains the FSM, counter, three shift registers, the borrow flop, and output regs.

## Test plan
- WIDTH=8, a=0x5A, b=0x21, start for 1 cycle → done exactly 8 cycles after the accepting edge; diff=0x39, bout=0, ovf=0; busy high for 8 cycles.
- a=0x00, b=0x01 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Start, then pulse start again at cycle 3 of RUN with a=0x10, b=0x01 → second request ignored; single done with the first result. Back-to-back start held high → second operation accepted in IDLE, done cycles spaced 10 apart.
- Reset at cycle 4 of RUN → next edge: busy=0, diff=0, bout=0, ovf=0; no done pulse. A following start with a=0x03, b=0x05 → diff=0xFE, bout=1.
- Randomized 1000 operands at WIDTH=8 and WIDTH=13, compared against a reference model of a − b → diff, bout and ovf all match.
